fetch_stage: RTL

Instruction-fetch stage for the 64-bit-instruction CPU core. Generates the program counter, drives the instruction ROM's chip-enable and byte address, and captures the returned 64-bit instruction into the IF/ID pipeline register for the decode stage. Handles sequential fetch, branch redirect from ID, pipeline stall and exception flush.

---
 rtl/fetch_stage_if.sv | 47 ++++
 rtl/fetch_stage.sv | 133 +++++++++++++
 2 files changed

// File: rtl/fetch_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_stage_if
//   Bundle between the fetch stage and its surroundings: the pipeline
//   controls from ID and the exception unit, the instruction ROM bus, the
//   IF/ID register outputs and the misaligned-redirect report.
//   modport master : the fetch stage itself.
//   modport slave  : the environment (ROM, decode, hazard/exception control).
// ---------------------------------------------------------------------------
interface fetch_stage_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 64
);
  // pipeline control
  logic              stall_if;
  logic              stall_id;
  logic              flush;
  logic [ADDR_W-1:0] new_pc;
  logic              branch_flag_i;
  logic [ADDR_W-1:0] branch_target_i;
  // instruction ROM bus
  logic              rom_ce;
  logic [ADDR_W-1:0] rom_addr;
  logic [INST_W-1:0] rom_inst;
  // IF/ID register
  logic [ADDR_W-1:0] id_pc;
  logic [INST_W-1:0] id_inst;
  logic              id_valid;
  // misaligned redirect report
  logic              misalign_o;
  logic [ADDR_W-1:0] misalign_addr_o;

  modport master (
    input  stall_if, stall_id, flush, new_pc, branch_flag_i, branch_target_i,
    input  rom_inst,
    output rom_ce, rom_addr,
    output id_pc, id_inst, id_valid,
    output misalign_o, misalign_addr_o
  );

  modport slave (
    output stall_if, stall_id, flush, new_pc, branch_flag_i, branch_target_i,
    output rom_inst,
    input  rom_ce, rom_addr,
    input  id_pc, id_inst, id_valid,
    input  misalign_o, misalign_addr_o
  );
endinterface

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch for the 64-bit-instruction core. Holds the PC, drives
//   the instruction ROM (chip-enable + byte address = PC), and captures the
//   returned instruction into the IF/ID register. Handles sequential fetch,
//   branch redirect from ID, stalls and exception flush.
//
//   Ports:
//     clk  - clock, rising edge
//     rst  - asynchronous active-high reset
//     bus  - fetch_stage_if.master: controls, ROM bus, IF/ID outputs,
//            misaligned-redirect report
//
//   Optional feature macro: FETCH_MISALIGN_EXC_EN
//     defined   : a flush or accepted branch to an address with [2:0]!=0
//                 pulses misalign_o for one cycle and latches the raw address
//                 in misalign_addr_o.
//     undefined : misaligned redirects are silently aligned; misalign_o and
//                 misalign_addr_o are tied to 0.
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter int              ADDR_W   = 32,
  parameter int              INST_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic           clk,
  input logic           rst,
  fetch_stage_if.master bus
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(7));
  localparam logic [ADDR_W-1:0] INST_BYTES = ADDR_W'(8);

  function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] a);
    return a & ALIGN_MASK;
  endfunction

  logic              rom_ce_q,   rom_ce_d;
  logic [ADDR_W-1:0] pc_q,       pc_d;
  logic [ADDR_W-1:0] id_pc_q,    id_pc_d;
  logic [INST_W-1:0] id_inst_q,  id_inst_d;
  logic              id_valid_q, id_valid_d;
  logic              stall_eff;
  logic              branch_take;

  // stall_id alone still freezes the PC, otherwise the instruction held in
  // ID would be overtaken by the fetch behind it.
  assign stall_eff   = bus.stall_if | bus.stall_id;
  assign branch_take = bus.branch_flag_i & ~stall_eff;

  // ---- IF stage: PC generation ----
  always_comb begin
    rom_ce_d = 1'b1;
    pc_d     = pc_q;
    if (rom_ce_q) begin
      if (bus.flush)        pc_d = align_addr(bus.new_pc);
      else if (branch_take) pc_d = align_addr(bus.branch_target_i);
      else if (!stall_eff)  pc_d = pc_q + INST_BYTES;
    end
  end

  // ---- IF/ID boundary ----
  always_comb begin
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    id_valid_d = id_valid_q;
    if (bus.flush || (!bus.stall_id && (bus.stall_if || bus.branch_flag_i))) begin
      // bubble: also squashes the wrong-path sequential fetch after a branch
      id_pc_d    = '0;
      id_inst_d  = '0;
      id_valid_d = 1'b0;
    end else if (!bus.stall_id) begin
      id_pc_d    = pc_q;
      id_inst_d  = bus.rom_inst;
      id_valid_d = rom_ce_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_ce_q   <= 1'b0;
      pc_q       <= RESET_PC;
      id_pc_q    <= '0;
      id_inst_q  <= '0;
      id_valid_q <= 1'b0;
    end else begin
      rom_ce_q   <= rom_ce_d;
      pc_q       <= pc_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
      id_valid_q <= id_valid_d;
    end
  end

  assign bus.rom_ce   = rom_ce_q;
  assign bus.rom_addr = pc_q;
  assign bus.id_pc    = id_pc_q;
  assign bus.id_inst  = id_inst_q;
  assign bus.id_valid = id_valid_q;

`ifdef FETCH_MISALIGN_EXC_EN
  logic              misalign_q,      misalign_d;
  logic [ADDR_W-1:0] misalign_addr_q, misalign_addr_d;
  logic [ADDR_W-1:0] redirect_addr;
  logic              redirect_vld;

  // Only a redirect that actually loads the PC can raise the report; flush
  // wins over a coincident branch.
  always_comb begin
    redirect_vld    = rom_ce_q & (bus.flush | branch_take);
    redirect_addr   = bus.flush ? bus.new_pc : bus.branch_target_i;
    misalign_d      = redirect_vld & (redirect_addr[2:0] != 3'b000);
    misalign_addr_d = misalign_d ? redirect_addr : misalign_addr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_q      <= 1'b0;
      misalign_addr_q <= '0;
    end else begin
      misalign_q      <= misalign_d;
      misalign_addr_q <= misalign_addr_d;
    end
  end

  assign bus.misalign_o      = misalign_q;
  assign bus.misalign_addr_o = misalign_addr_q;
`else
  assign bus.misalign_o      = 1'b0;
  assign bus.misalign_addr_o = '0;
`endif

endmodule
